// File: rtl/afifo_push_arb_pkg.sv
// afifo_arb_pkg: shared FSM state type and id-width helper for the FIFO push arbiter.
package afifo_arb_pkg;
    typedef enum logic {IDLE, LOCKED} state_t;

    function automatic int id_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction
endpackage

// File: rtl/afifo_push_arb_if.sv
// afifo_push_arb_if: requester handshakes, FIFO write side and arbiter status in one bundle.
interface afifo_push_arb_if #(parameter int R = 4, parameter int W = 32);
    localparam int ID_W = afifo_arb_pkg::id_w(R);
    logic              en;
    logic [R-1:0]      req_vld;
    logic [R-1:0]      req_last;
    logic [R*W-1:0]    req_data;
    logic [R-1:0]      req_rdy;
    logic              full_r;
    logic              push;
    logic [ID_W+W-1:0] push_data;
    logic              busy_r;
    logic [ID_W-1:0]   owner_r;

    modport master (
        output en, req_vld, req_last, req_data, full_r,
        input  req_rdy, push, push_data, busy_r, owner_r
    );
    modport slave (
        input  en, req_vld, req_last, req_data, full_r,
        output req_rdy, push, push_data, busy_r, owner_r
    );
endinterface

// File: rtl/afifo_push_arb_rr_sel.sv
// rr_sel: round-robin pick of the first set request at or after a priority index.
module rr_sel #(
    parameter  int R    = 4,
    localparam int ID_W = afifo_arb_pkg::id_w(R)
) (
    input  logic [R-1:0]    i_req,
    input  logic [ID_W-1:0] i_prio,
    output logic            o_found,
    output logic [ID_W-1:0] o_idx
);
    logic [R-1:0]    w_rot;
    logic [ID_W-1:0] w_enc;
    logic [ID_W:0]   w_sum;

    always_comb begin
        w_rot   = R'({i_req, i_req} >> i_prio);
        o_found = |i_req;
        w_enc   = '0;
        for (int k = R - 1; k >= 0; k--)
            if (w_rot[k]) w_enc = ID_W'(k);
        w_sum = {1'b0, w_enc} + {1'b0, i_prio};
        o_idx = (w_sum >= (ID_W+1)'(R)) ? ID_W'(w_sum - (ID_W+1)'(R)) : w_sum[ID_W-1:0];
    end
endmodule

// File: rtl/afifo_push_arb.sv
// afifo_push_arb: round-robin packet arbiter sharing one async FIFO push port among R requesters.
module afifo_push_arb import afifo_arb_pkg::*; #(
    parameter int R = 4,
    parameter int W = 32
) (
    input logic clk,
    input logic rst,
    afifo_push_arb_if.slave bus
);
    localparam int ID_W = id_w(R);

    state_t          r_state, w_next;
    logic [ID_W-1:0] r_prio, r_owner, w_sel, w_gnt, w_prio_nxt;
    logic            r_bubble, w_found, w_push, w_last, w_done;
    logic [R-1:0]    w_rdy;

    rr_sel #(.R(R)) u_sel (
        .i_req   (bus.req_vld),
        .i_prio  (r_prio),
        .o_found (w_found),
        .o_idx   (w_sel)
    );

    // r_bubble forces the idle cycle that follows every packet completion
    always_comb begin
        w_gnt = (r_state == LOCKED) ? r_owner : w_sel;
        w_rdy = '0;
        if (r_state == LOCKED) w_rdy[r_owner] = !bus.full_r;
        else w_rdy[w_sel] = bus.en & !bus.full_r & w_found & !r_bubble;
        w_push     = |(bus.req_vld & w_rdy);
        w_last     = bus.req_last[w_gnt];
        w_done     = w_push & w_last;
        w_prio_nxt = (w_gnt == ID_W'(R - 1)) ? '0 : w_gnt + ID_W'(1);
        w_next     = r_state;
        if (w_push) w_next = w_last ? IDLE : LOCKED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_prio   <= '0;
            r_owner  <= '0;
            r_bubble <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_bubble <= w_done;
            if (w_done) r_prio <= w_prio_nxt;
            if (w_push) r_owner <= w_last ? '0 : w_gnt;
        end
    end

    assign bus.req_rdy   = w_rdy;
    assign bus.push      = w_push;
    assign bus.push_data = {w_gnt, bus.req_data[w_gnt*W +: W]};
    assign bus.busy_r    = (r_state == LOCKED);
    assign bus.owner_r   = r_owner;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(w_rdy));
            assert (!(w_push && bus.full_r));
            assert (r_state != LOCKED || (w_rdy & ~(R'(1) << r_owner)) == '0);
        end
    end
endmodule
